hwag_angle_channel: RTL

Angle-driven output channel that sits directly downstream of the crank angle generator. It consumes the synchronized angle count (0..3839, 64 steps per tooth over 60 teeth) and the one-cycle angle-advance strobe. It drives one output high between a programmable on-angle and off-angle, including windows that span the revolution wrap. It is the building block for coil-dwell and injector outputs; one instance serves one output.

---
 rtl/hwag_angle_channel.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/hwag_angle_channel.sv
// Angle-window output channel: drives out high from on_angle to off_angle (wrap-safe).
// Optional on-time limit is built when HWAG_CH_TMO_EN is defined.
module hwag_angle_channel #(
  parameter int ANGLE_WIDTH = 24,
  parameter int ANGLE_TOP   = 3839,
  parameter int TMO_WIDTH   = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sync,
  input  logic [ANGLE_WIDTH-1:0] angle,
  input  logic                   angle_tick,
  input  logic                   ena,
  input  logic                   cfg_we,
  input  logic [ANGLE_WIDTH-1:0] on_angle,
  input  logic [ANGLE_WIDTH-1:0] off_angle,
  input  logic [TMO_WIDTH-1:0]   tmo_limit,
  output logic                   out,
  active,
  output logic                   upd_pending,
  output logic                   tmo_flag
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_REV,
    S_ARMED,
    S_ACTIVE
  } state_t;

  state_t r_state;

  logic [ANGLE_WIDTH-1:0] r_pend_on, r_pend_off;
  logic [ANGLE_WIDTH-1:0] r_work_on, r_work_off;
  logic                   r_out, r_active, r_upd;

  logic                   w_run;
  logic                   w_boundary;
  logic [ANGLE_WIDTH-1:0] w_load_on, w_load_off;
  logic [ANGLE_WIDTH-1:0] w_on_eff, w_off_eff;
  logic                   w_window_ok;
  logic                   w_on_hit, w_off_hit;
  logic                   w_tmo_expire;

  localparam logic [ANGLE_WIDTH-1:0] LP_TOP = ANGLE_WIDTH'(ANGLE_TOP);

  // Values loaded on a boundary take effect for matching in that same cycle.
  always_comb begin
    w_run       = sync & ena;
    w_boundary  = angle_tick & (angle == '0);
    w_load_on   = cfg_we ? on_angle  : r_pend_on;
    w_load_off  = cfg_we ? off_angle : r_pend_off;
    w_on_eff    = w_boundary ? w_load_on  : r_work_on;
    w_off_eff   = w_boundary ? w_load_off : r_work_off;
    w_window_ok = (w_on_eff != w_off_eff);
    w_on_hit    = angle_tick & w_window_ok & (angle == w_on_eff)  & (w_on_eff  <= LP_TOP);
    w_off_hit   = angle_tick & w_window_ok & (angle == w_off_eff) & (w_off_eff <= LP_TOP);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pend_on  <= '0;
      r_pend_off <= '0;
      r_work_on  <= '0;
      r_work_off <= '0;
      r_upd      <= 1'b0;
    end else begin
      if (cfg_we) begin
        r_pend_on  <= on_angle;
        r_pend_off <= off_angle;
      end
      if (w_boundary) begin
        r_work_on  <= w_load_on;
        r_work_off <= w_load_off;
        r_upd      <= 1'b0;
      end else if (cfg_we) begin
        r_upd      <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_out    <= 1'b0;
      r_active <= 1'b0;
    end else if (!w_run) begin
      r_state  <= S_IDLE;
      r_out    <= 1'b0;
      r_active <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_WAIT_REV;
        end
        S_WAIT_REV: begin
          if (w_boundary) begin
            if (w_on_hit) begin
              r_state  <= S_ACTIVE;
              r_out    <= 1'b1;
              r_active <= 1'b1;
            end else begin
              r_state  <= S_ARMED;
            end
          end
        end
        S_ARMED: begin
          if (w_on_hit) begin
            r_state  <= S_ACTIVE;
            r_out    <= 1'b1;
            r_active <= 1'b1;
          end
        end
        S_ACTIVE: begin
          if (w_off_hit || w_tmo_expire) begin
            r_state  <= S_ARMED;
            r_out    <= 1'b0;
            r_active <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_out    <= 1'b0;
          r_active <= 1'b0;
        end
      endcase
    end
  end

`ifdef HWAG_CH_TMO_EN
  logic [TMO_WIDTH-1:0] r_tmo_cnt;
  logic                 r_tmo_flag;

  // Counter holds the number of ACTIVE cycles already spent, so expiry hits on the limit-th one.
  assign w_tmo_expire = (r_state == S_ACTIVE) && (tmo_limit != '0) &&
                        (r_tmo_cnt == tmo_limit - 1'b1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tmo_cnt  <= '0;
      r_tmo_flag <= 1'b0;
    end else begin
      if (r_state != S_ACTIVE) r_tmo_cnt <= '0;
      else                     r_tmo_cnt <= r_tmo_cnt + 1'b1;
      if (w_run && w_tmo_expire && !w_off_hit) r_tmo_flag <= 1'b1;
      else if (cfg_we)                         r_tmo_flag <= 1'b0;
    end
  end

  assign tmo_flag = r_tmo_flag;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^tmo_limit;
  assign w_tmo_expire = 1'b0;
  assign tmo_flag     = 1'b0;
`endif

  assign out         = r_out;
  assign active      = r_active;
  assign upd_pending = r_upd;

endmodule
